// File: rtl/corr_accumulator.sv
// corr_accumulator
//   Coherent-integration stage wrapped around an external registered 32-bit
//   multiplier. Operand pairs arrive on a valid/ready stream. They pass
//   straight through to the multiplier. One cycle later the multiplier
//   result is folded into a wide signed accumulator. After INT_LEN products
//   the sum is presented on a valid/ready output.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begins an integration when idle
//   in_valid/in_ready     operand stream handshake, in_a/in_b signed operands
//   mul_en, mul_op_a/b    multiplier enable and operands (combinational)
//   mul_result            registered product of the previously enabled pair
//   out_valid/out_ready   result handshake, out_sum signed ACC_W-bit sum
//   busy                  any state other than IDLE
//   overflow              sticky signed-wrap flag for the current integration
module corr_accumulator #(
    parameter int INT_LEN = 1023,
    parameter int ACC_W   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             mul_en,
    output logic [31:0]      mul_op_a,
    output logic [31:0]      mul_op_b,
    input  logic [31:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] LAST = 16'(INT_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             hs;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    assign in_ready = (state_q == S_RUN);
    assign hs       = in_valid & in_ready;
    assign mul_en   = hs;
    assign mul_op_a = in_a;
    assign mul_op_b = in_b;

    // The multiplier only returns the low 32 bits; treat them as signed.
    assign prod_ext = {{(ACC_W-32){mul_result[31]}}, mul_result};
    assign sum      = acc_q + prod_ext;
    // Signed wrap: equal-sign addends producing a result of the other sign.
    assign wrap     = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        // pend marks that mul_result now holds the product of last cycle's
        // handshake; it is the only time mul_result is meaningful.
        pend_d  = hs;

        if (pend_q) begin
            acc_d = sum;
            if (wrap) ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (hs) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST) state_d = S_DRAIN;
                end
            end
            // One cycle for the final product to land in acc.
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign out_sum   = out_valid ? acc_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_corr_accumulator.sv
module tb_corr_accumulator;

    localparam int N = 4;

    function automatic int len_of(input int g);
        case (g)
            0: return 4;
            1: return 3;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int accw_of(input int g);
        case (g)
            1, 2: return 33;
            default: return 48;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s    [N];
    logic        in_valid_s [N];
    logic        in_ready_s [N];
    logic [31:0] a_s        [N];
    logic [31:0] b_s        [N];
    logic        mul_en_s   [N];
    logic [31:0] opa_s      [N];
    logic [31:0] opb_s      [N];
    logic        out_valid_s[N];
    logic        out_ready_s[N];
    logic [63:0] sum_s      [N];
    logic        busy_s     [N];
    logic        ovf_s      [N];

    int errors = 0;
    int checks = 0;
    int pa [16];
    int pb [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = len_of(g);
        localparam int W = accw_of(g);
        logic [W-1:0] s;
        logic [31:0]  res;

        corr_accumulator #(.INT_LEN(L), .ACC_W(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .in_a      (a_s[g]),
            .in_b      (b_s[g]),
            .mul_en    (mul_en_s[g]),
            .mul_op_a  (opa_s[g]),
            .mul_op_b  (opb_s[g]),
            .mul_result(res),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .out_sum   (s),
            .busy      (busy_s[g]),
            .overflow  (ovf_s[g])
        );

        assign sum_s[g] = {{(64-W){s[W-1]}}, s};

        // Registered multiplier returning the low 32 bits of the product.
        always_ff @(posedge clk)
            if (mul_en_s[g]) res <= 32'($signed(opa_s[g]) * $signed(opb_s[g]));
    end

    // Reference: exact integer sum of truncated products, tracking whether
    // any running total leaves the signed W-bit range, then wrapping.
    function automatic void model(input int n, input int w, output longint s, output bit ov);
        longint acc, t, mx, mn, p;
        acc = 0;
        ov  = 1'b0;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        for (int i = 0; i < n; i++) begin
            p = longint'(pa[i]) * longint'(pb[i]);
            p = longint'(int'(p));
            t = acc + p;
            if (t > mx || t < mn) ov = 1'b1;
            t   = t <<< (64 - w);
            acc = t >>> (64 - w);
        end
        s = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int g);
        start_s[g] = 1'b1;
        tick();
        start_s[g] = 1'b0;
        checks++;
        if (in_ready_s[g] !== 1'b1 || busy_s[g] !== 1'b1) begin
            errors++;
            $display("FAIL start_ack g%0d: in_ready=%b busy=%b, want 1 1", g, in_ready_s[g], busy_s[g]);
        end
    endtask

    task automatic feed(input int g, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            a_s[g] = pa[i];
            b_s[g] = pb[i];
            in_valid_s[g] = 1'b1;
            #1;
            checks++;
            if (in_ready_s[g] !== 1'b1 || mul_en_s[g] !== 1'b1 ||
                opa_s[g] !== a_s[g] || opb_s[g] !== b_s[g]) begin
                errors++;
                $display("FAIL handshake g%0d #%0d: rdy=%b en=%b opa=%h opb=%h, want 1 1 %h %h",
                         g, i, in_ready_s[g], mul_en_s[g], opa_s[g], opb_s[g], a_s[g], b_s[g]);
            end
            tick();
            in_valid_s[g] = 1'b0;
            a_s[g] = $urandom;
            b_s[g] = $urandom;
            if (i < n - 1) begin
                for (int k = 0; k < gap; k++) begin
                    #1;
                    checks++;
                    if (mul_en_s[g] !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_mul_en g%0d: mul_en=%b, want 0", g, mul_en_s[g]);
                    end
                    tick();
                end
            end
        end
    endtask

    // Called one step after the last handshake edge: expects one drain cycle.
    task automatic finish(input int g, output longint got, output bit got_ov);
        int cyc;
        checks++;
        if (in_ready_s[g] !== 1'b0 || out_valid_s[g] !== 1'b0) begin
            errors++;
            $display("FAIL drain g%0d: in_ready=%b out_valid=%b, want 0 0", g, in_ready_s[g], out_valid_s[g]);
        end
        tick();
        checks++;
        if (out_valid_s[g] !== 1'b1) begin
            errors++;
            $display("FAIL latency g%0d: out_valid=%b one cycle after last handshake, want 1", g, out_valid_s[g]);
        end
        cyc = 0;
        while (out_valid_s[g] !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (cyc >= 50) begin
            errors++;
            $display("FAIL done_timeout g%0d: out_valid never rose", g);
        end
        got    = sum_s[g];
        got_ov = ovf_s[g];
    endtask

    task automatic release_out(input int g);
        out_ready_s[g] = 1'b1;
        tick();
        out_ready_s[g] = 1'b0;
        checks++;
        if (out_valid_s[g] !== 1'b0 || busy_s[g] !== 1'b0 || in_ready_s[g] !== 1'b0) begin
            errors++;
            $display("FAIL to_idle g%0d: out_valid=%b busy=%b in_ready=%b, want 0 0 0",
                     g, out_valid_s[g], busy_s[g], in_ready_s[g]);
        end
    endtask

    task automatic integrate_check(input int g, input int gap, input string name);
        longint got, exp_s;
        bit     got_ov, exp_ov;
        model(len_of(g), accw_of(g), exp_s, exp_ov);
        do_start(g);
        feed(g, len_of(g), gap);
        finish(g, got, got_ov);
        checks++;
        if (got !== exp_s || got_ov !== exp_ov) begin
            errors++;
            $display("FAIL %s g%0d: sum=%0d ovf=%b, want sum=%0d ovf=%b", name, g, got, got_ov, exp_s, exp_ov);
        end
        release_out(g);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (in_ready_s[g] !== 1'b0 || out_valid_s[g] !== 1'b0 || busy_s[g] !== 1'b0 ||
                ovf_s[g] !== 1'b0 || sum_s[g] !== 64'd0) begin
                errors++;
                $display("FAIL reset g%0d: rdy=%b vld=%b busy=%b ovf=%b sum=%0d, want all 0",
                         g, in_ready_s[g], out_valid_s[g], busy_s[g], ovf_s[g], sum_s[g]);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_basic();
        pa[0] = 3;  pb[0] = 5;
        pa[1] = -2; pb[1] = 7;
        pa[2] = 10; pb[2] = 10;
        pa[3] = -1; pb[3] = -1;
    endtask

    task automatic test_basic();
        longint got;
        bit     ov;
        load_basic();
        do_start(0);
        feed(0, 4, 0);
        finish(0, got, ov);
        checks++;
        if (got !== 64'sd102 || ov !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: sum=%0d ovf=%b, want 102 0", got, ov);
        end
        release_out(0);
    endtask

    task automatic test_gapped();
        load_basic();
        integrate_check(0, 2, "gapped_sum");
    endtask

    task automatic test_backpressure();
        longint got;
        bit     ov, exp_ov;
        longint exp_s;
        for (int i = 0; i < 4; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        model(4, 48, exp_s, exp_ov);
        do_start(0);
        feed(0, 4, 0);
        finish(0, got, ov);
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL bp_sum: sum=%0d, want %0d", got, exp_s);
        end
        for (int c = 0; c < 10; c++) begin
            start_s[0]    = (c == 3);
            in_valid_s[0] = (c >= 5);
            #1;
            checks++;
            if (sum_s[0] !== exp_s || ovf_s[0] !== exp_ov || out_valid_s[0] !== 1'b1 ||
                in_ready_s[0] !== 1'b0 || mul_en_s[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c%0d: sum=%0d ovf=%b vld=%b rdy=%b en=%b, want %0d %b 1 0 0",
                         c, sum_s[0], ovf_s[0], out_valid_s[0], in_ready_s[0], mul_en_s[0], exp_s, exp_ov);
            end
            tick();
        end
        start_s[0]    = 1'b0;
        in_valid_s[0] = 1'b0;
        release_out(0);
    endtask

    task automatic test_overflow();
        longint got;
        bit     ov;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 65535;
            pb[i] = 32767;
        end
        do_start(1);
        feed(1, 3, 0);
        finish(1, got, ov);
        checks++;
        if (got !== -64'sd2147778557 || ov !== 1'b1) begin
            errors++;
            $display("FAIL overflow_wrap: sum=%0d ovf=%b, want -2147778557 1", got, ov);
        end
        release_out(1);
        checks++;
        if (ovf_s[1] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b in IDLE, want 1", ovf_s[1]);
        end
        pa[0] = 1; pb[0] = 1;
        do_start(2);
        feed(2, 1, 0);
        finish(2, got, ov);
        checks++;
        if (got !== 64'sd1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL len1_sum: sum=%0d ovf=%b, want 1 0", got, ov);
        end
        release_out(2);
        for (int i = 0; i < 3; i++) begin
            pa[i] = 1;
            pb[i] = 1;
        end
        integrate_check(1, 0, "ovf_cleared");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                pa[i] = $urandom;
                pb[i] = $urandom;
            end
            integrate_check(3, 0, "b2b");
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            int g;
            g = r % N;
            for (int i = 0; i < len_of(g); i++) begin
                pa[i] = (r % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
                pb[i] = int'($urandom);
            end
            integrate_check(g, int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_reset_mid();
        longint got;
        bit     ov;
        for (int i = 0; i < 5; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        do_start(3);
        feed(3, 5, 0);
        in_valid_s[3] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready_s[3] !== 1'b0 || out_valid_s[3] !== 1'b0 || busy_s[3] !== 1'b0 ||
            ovf_s[3] !== 1'b0 || sum_s[3] !== 64'd0 || mul_en_s[3] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b ovf=%b sum=%0d en=%b, want all 0",
                     in_ready_s[3], out_valid_s[3], busy_s[3], ovf_s[3], sum_s[3], mul_en_s[3]);
        end
        in_valid_s[3] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            pa[i] = 1;
            pb[i] = 1;
        end
        do_start(3);
        feed(3, 8, 1);
        finish(3, got, ov);
        checks++;
        if (got !== 64'sd8 || ov !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_sum: sum=%0d ovf=%b, want 8 0", got, ov);
        end
        release_out(3);
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            start_s[g]     = 1'b0;
            in_valid_s[g]  = 1'b0;
            a_s[g]         = '0;
            b_s[g]         = '0;
            out_ready_s[g] = 1'b0;
        end
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/corr_accumulator.md
# corr_accumulator

Coherent-integration stage that sits around the 32-bit block multiplier in the acquisition datapath. Accepts operand pairs (e.g. sample × local replica) over a valid/ready stream and forwards them to the multiplier. Consumes the multiplier's registered 32-bit result and sums INT_LEN products into a wide signed accumulator. Presents the finished sum on a valid/ready output.

## Interface
- INT_LEN, 1023, products per integration; legal range 1..65535.
- ACC_W, 48, accumulator and output width; legal range 33..64.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins an integration when idle.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_a  in  32  signed operand A.
- in_b  in  32  signed operand B.
- mul_en  out  1  multiplier enable; equals in_valid & in_ready, combinational.
- mul_op_a  out  32  equals in_a, combinational pass-through.
- mul_op_b  out  32  equals in_b, combinational pass-through.
- mul_result  in  32  multiplier result; holds the product of the pair captured at the previous enabled edge.
- out_valid  out  1  out_sum valid.
- out_ready  in  1  consumer accepts the sum.
- out_sum  out  ACC_W  signed integration result.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; set on any signed accumulator wrap during the current integration.

## Operation
- States:
  - IDLE: in_ready=0, out_valid=0.
    - start → RUN.
    - Same edge: acc=0, cnt=0, overflow=0, pend=0.
  - RUN: in_ready=1.
    - Handshake (in_valid & in_ready): cnt+1.
    - Handshake with cnt==INT_LEN-1 → DRAIN.
  - DRAIN: in_ready=0.
    - Unconditional → DONE after one cycle. This lets the last product reach acc.
  - DONE: out_valid=1, out_sum=acc, held stable.
    - out_ready → IDLE.
- pend: register set to the handshake of the previous cycle.
- Accumulation: when pend=1, acc <= acc + sign_extend_ACC_W(mul_result). mul_result is read only when pend=1; it is ignored otherwise.
- Overflow:
  - Condition: both addends have the same sign and the sum has the opposite sign.
  - Effect: overflow is set. acc keeps the wrapped two's-complement value; no saturation.
- Ignored events:
  - start outside IDLE.
  - in_valid outside RUN; no handshake occurs.
- Sign handling: mul_result is treated as the signed low 32 bits of the product. Upper product bits are not recovered.
- Reset (rst_n=0, any time, including mid-integration):
  - State: IDLE.
  - acc, cnt, pend: 0.
  - Outputs: out_valid=0, out_sum=0, overflow=0, busy=0, in_ready=0.
  - An in-flight product is discarded.

## Timing
- start sampled at edge E → in_ready=1 in the cycle after E.
- Handshake at edge H → multiplier captures at H → acc includes that product after edge H+1.
- Last handshake at edge H → DRAIN during the cycle after H → out_valid=1 after edge H+1. This is one idle cycle of in_ready=0 before the result.
- Throughput: one pair per cycle in RUN; in_valid gaps are allowed and only delay completion.
- out_valid & out_ready at edge D → IDLE after D. A new start is accepted at the edge after D at the earliest. Minimum gap between integrations is therefore 2 cycles after the output handshake.
- INT_LEN=1: single handshake → DRAIN → DONE; same timing as above.
- out_ready held low: DONE persists indefinitely. out_sum and overflow stay stable.

## Test plan
- Basic sum, INT_LEN=4, back-to-back pairs:
  - Pairs (3,5),(−2,7),(10,10),(−1,−1).
  - Required: out_sum=102, overflow=0, out_valid exactly one cycle after the 4th handshake.
- Gapped input, INT_LEN=4, same pairs with in_valid low 2 cycles between each:
  - Required: out_sum=102.
  - Required: mul_en is never high while in_valid is low.
- Output backpressure:
  - Hold out_ready=0 for 10 cycles in DONE, and pulse start during that window.
  - Required: out_sum stable and in_ready=0 throughout; the start is ignored; IDLE follows the out_ready handshake.
- Overflow, ACC_W=33, INT_LEN=3:
  - Pairs (65535,32767)×3, giving 2147385345 each.
  - Required: sum wraps and overflow=1.
  - Next integration (INT_LEN=1, pair (1,1)): overflow=0 and out_sum=1.
- Reset mid-integration, INT_LEN=8:
  - Assert rst_n=0 after 5 handshakes.
  - Required: all outputs 0 immediately, state IDLE.
  - A new start then sums 8 pairs of (1,1) to out_sum=8.
